// File: rtl/ecc_verdict_sink.sv
// Receive end of the RS(544,522) over-capability verdict path: queues per-codeword verdicts,
// aligns them with output frames, reports pass/fail and keeps decode statistics (ECC_STATS_EN).
module ecc_verdict_sink #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             result_valid_i,
  input  logic             exceed_i,
  input  logic [3:0]       root_cnt_i,
  input  logic             out_valid_i,
  input  logic             out_sop_i,
  input  logic             out_eop_i,
  input  logic             clear_stats_i,
  output logic             frame_fail_o,
  output logic [3:0]       frame_roots_o,
  output logic             status_valid_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] cw_total_o,
  output logic [CNT_W-1:0] cw_fail_o,
  output logic [CNT_W-1:0] sym_corr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_FRAME} state_e;

  state_e        state;
  logic          rv_q;
  logic [4:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic       push, pop, empty, full, push_ok, pop_ok;
  logic       beat_sop, beat_eop, close_old, close_new;
  logic [4:0] head;
  logic       new_fail;
  logic [3:0] new_roots;

  assign beat_sop = out_valid_i & out_sop_i;
  assign beat_eop = out_valid_i & out_eop_i;
  assign push     = result_valid_i & ~rv_q;
  assign pop      = beat_sop;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign push_ok  = push & (~full | pop_ok);

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    head      = mem[rd_ptr];
    new_fail  = empty | head[4];
    new_roots = new_fail ? 4'd0 : head[3:0];
    close_old = (state == S_FRAME) & (beat_sop | beat_eop);
    close_new = beat_sop & beat_eop;
  end

  // NOTE: storage array has no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= {exceed_i, root_cnt_i};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      rv_q           <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      frame_fail_o   <= 1'b0;
      frame_roots_o  <= 4'd0;
      status_valid_o <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
      proto_err_o    <= 1'b0;
    end else begin
      rv_q <= result_valid_i;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);

      if (push & ~push_ok) overflow_o  <= 1'b1;
      if (pop & empty)     underflow_o <= 1'b1;

      status_valid_o <= close_old | close_new;
      if (beat_sop) begin
        frame_fail_o  <= new_fail;
        frame_roots_o <= new_roots;
      end

      case (state)
        S_IDLE: begin
          if (beat_sop)      state <= beat_eop ? S_IDLE : S_FRAME;
          else if (beat_eop) proto_err_o <= 1'b1;
        end
        S_FRAME: begin
          if (beat_sop) begin
            proto_err_o <= 1'b1;
            state       <= beat_eop ? S_IDLE : S_FRAME;
          end else if (beat_eop) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ECC_STATS_EN
  logic [1:0] n_done, n_fail;
  logic [4:0] roots_add;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Up to two frames can close in one cycle: the open one and a single-beat new one.
  always_comb begin
    n_done    = 2'(close_old) + 2'(close_new);
    n_fail    = 2'(close_old & frame_fail_o) + 2'(close_new & new_fail);
    roots_add = 5'(close_old ? frame_roots_o : 4'd0) + 5'(close_new ? new_roots : 4'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cw_total_o <= '0;
      cw_fail_o  <= '0;
      sym_corr_o <= '0;
    end else if (clear_stats_i) begin
      cw_total_o <= '0;
      cw_fail_o  <= '0;
      sym_corr_o <= '0;
    end else begin
      cw_total_o <= sat_add(cw_total_o, CNT_W'(n_done));
      cw_fail_o  <= sat_add(cw_fail_o,  CNT_W'(n_fail));
      sym_corr_o <= sat_add(sym_corr_o, CNT_W'(roots_add));
    end
  end
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats_i;
  assign cw_total_o = '0;
  assign cw_fail_o  = '0;
  assign sym_corr_o = '0;
`endif

endmodule
